// File: rtl/input_pixel_queue_pkg.sv
// Shared constants and types for the input pixel queue and the Layer 1 controller.
// Pixel thresholding helper and FSM state encoding live here too.
package input_pixel_queue_pkg;

    localparam int unsigned IMAGE_PIXELS = 784;
    localparam int unsigned PIXEL_WIDTH  = 8;
    localparam int unsigned INDEX_WIDTH  = 10;
    localparam int unsigned QUEUE_DEPTH  = 1024;
    localparam int unsigned THRESHOLD    = 128;
    localparam int unsigned COUNT_WIDTH  = INDEX_WIDTH + 1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_FINISHED = 2'd2
    } state_e;

    // A pixel contributes to Layer 1 only when it reaches the threshold.
    function automatic logic is_active(input pixel_t pix);
        return (pix >= PIXEL_WIDTH'(THRESHOLD)) ? TRUE : FALSE;
    endfunction

endpackage

// File: rtl/input_pixel_queue_if.sv
// Pixel stream in, sparse active-index queue out.
// master drives the image stream and pop requests; slave is the queue block.
interface input_pixel_queue_if;
    import input_pixel_queue_pkg::*;

    logic   imageStart;
    logic   pixelValid;
    pixel_t pixelIn;
    logic   pixelReady;
    logic   dequeue;
    logic   inputsRecieved;
    index_t queueOut;
    logic   queueEmpty;
    logic   queueFinished;
    count_t activeCount;
    logic   overflow;

    modport master (
        output imageStart, pixelValid, pixelIn, dequeue, inputsRecieved,
        input  pixelReady, queueOut, queueEmpty, queueFinished, activeCount, overflow
    );

    modport slave (
        input  imageStart, pixelValid, pixelIn, dequeue, inputsRecieved,
        output pixelReady, queueOut, queueEmpty, queueFinished, activeCount, overflow
    );

endinterface

// File: rtl/input_pixel_queue_index_fifo.sv
// First-word-fall-through FIFO of pixel indices with a registered head.
// Full/empty derive from an occupancy count; pointers wrap modulo QUEUE_DEPTH.
module input_pixel_queue_index_fifo
    import input_pixel_queue_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   push,
    input  logic   pop,
    input  index_t din,
    output index_t dout,
    output logic   empty,
    output logic   full,
    output count_t count
);

    index_t mem_q [QUEUE_DEPTH];

    index_t wr_ptr_q, wr_ptr_d;
    index_t rd_ptr_q, rd_ptr_d;
    count_t count_q,  count_d;
    index_t dout_q,   dout_d;
    logic   empty_q,  empty_d;
    logic   full_q,   full_d;

    index_t rd_next_c;
    logic   do_push_c;
    logic   do_pop_c;

    assign rd_next_c = rd_ptr_q + INDEX_WIDTH'(1);
    assign do_push_c = push && !full_q && !clear;
    assign do_pop_c  = pop && !empty_q && !clear && !push;

    // Head register is refreshed on the first push into an empty queue and on every pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        empty_d  = empty_q;
        full_d   = full_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
            empty_d  = TRUE;
            full_d   = FALSE;
        end else if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + INDEX_WIDTH'(1);
            count_d  = count_q + COUNT_WIDTH'(1);
            empty_d  = FALSE;
            full_d   = (count_q == COUNT_WIDTH'(QUEUE_DEPTH - 1));
            if (empty_q) begin
                dout_d = din;
            end
        end else if (do_pop_c) begin
            rd_ptr_d = rd_next_c;
            count_d  = count_q - COUNT_WIDTH'(1);
            full_d   = FALSE;
            empty_d  = (count_q == COUNT_WIDTH'(1));
            dout_d   = (count_q == COUNT_WIDTH'(1)) ? '0 : mem_q[rd_next_c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            empty_q  <= TRUE;
            full_q   <= FALSE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage carries no reset; unread entries are don't-care.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign count = count_q;

endmodule

// File: rtl/input_pixel_queue.sv
// Scans one raster image, thresholds each pixel and queues the indices of active pixels
// for the Layer 1 controller, which pops them once the whole image has been scanned.
module input_pixel_queue
    import input_pixel_queue_pkg::*;
(
    input logic               clk,
    input logic               reset,
    input_pixel_queue_if.slave bus
);

    state_e state_q, state_d;
    index_t pix_cnt_q, pix_cnt_d;
    count_t active_count_q, active_count_d;
    logic   overflow_q, overflow_d;
    logic   ready_q, ready_d;
    logic   finished_q, finished_d;

    logic   push_c;
    logic   pop_c;
    logic   clear_c;

    index_t fifo_dout;
    logic   fifo_empty;
    logic   fifo_full;
    count_t fifo_count;

    // Next-state, pixel accounting and FIFO control.
    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        active_count_d = active_count_q;
        overflow_d     = overflow_q;
        push_c         = FALSE;
        pop_c          = FALSE;
        clear_c        = FALSE;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.imageStart) begin
                    state_d        = ST_LOAD;
                    pix_cnt_d      = '0;
                    active_count_d = '0;
                    overflow_d     = FALSE;
                    clear_c        = TRUE;
                end
            end
            ST_LOAD: begin
                if (bus.pixelValid) begin
                    if (is_active(bus.pixelIn)) begin
                        if (fifo_full) begin
                            overflow_d = TRUE;
                        end else begin
                            push_c         = TRUE;
                            active_count_d = active_count_q + COUNT_WIDTH'(1);
                        end
                    end
                    if (pix_cnt_q == INDEX_WIDTH'(IMAGE_PIXELS - 1)) begin
                        state_d   = ST_FINISHED;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + INDEX_WIDTH'(1);
                    end
                end
            end
            ST_FINISHED: begin
                pop_c = bus.dequeue && !fifo_empty;
                // Release only once Layer 1 is done and nothing is left unread.
                if (bus.inputsRecieved && (fifo_count == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d    = (state_d == ST_LOAD);
        finished_d = (state_d == ST_FINISHED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pix_cnt_q      <= '0;
            active_count_q <= '0;
            overflow_q     <= FALSE;
            ready_q        <= FALSE;
            finished_q     <= FALSE;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            active_count_q <= active_count_d;
            overflow_q     <= overflow_d;
            ready_q        <= ready_d;
            finished_q     <= finished_d;
        end
    end

    input_pixel_queue_index_fifo u_index_fifo (
        .clk   (clk),
        .rst   (reset),
        .clear (clear_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   (pix_cnt_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign bus.pixelReady    = ready_q;
    assign bus.queueOut      = fifo_dout;
    assign bus.queueEmpty    = fifo_empty;
    assign bus.queueFinished = finished_q;
    assign bus.activeCount   = active_count_q;
    assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_input_pixel_queue.sv
// Bench for input_pixel_queue: fixed vectors, directed image sequences and random images
// compared every cycle against a queue-based reference model.
module tb_input_pixel_queue;
    import input_pixel_queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_pixel_queue_if bus();

    input_pixel_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 loading, 2 waiting for consumer.
    int m_phase;
    int m_pix;
    int m_q[$];
    int m_act;
    bit m_ovf;
    int img[IMAGE_PIXELS];

    typedef struct {
        bit start;
        bit valid;
        int pix;
        bit dq;
        bit ir;
        bit rdy;
        bit emp;
        bit fin;
        int out;
        int act;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pix   = 0;
        m_q.delete();
        m_act   = 0;
        m_ovf   = 0;
    endtask

    task automatic drive(input bit s, input bit v, input int p, input bit dq, input bit ir);
        bus.imageStart     = s;
        bus.pixelValid     = v;
        bus.pixelIn        = 8'(p);
        bus.dequeue        = dq;
        bus.inputsRecieved = ir;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pixelReady"},    32'(bus.pixelReady),    32'(m_phase == 1));
        chk({tag, ".queueFinished"}, 32'(bus.queueFinished), 32'(m_phase == 2));
        chk({tag, ".queueEmpty"},    32'(bus.queueEmpty),    32'(m_q.size() == 0));
        chk({tag, ".queueOut"},      32'(bus.queueOut),      (m_q.size() == 0) ? 32'd0 : 32'(m_q[0]));
        chk({tag, ".activeCount"},   32'(bus.activeCount),   32'(m_act));
        chk({tag, ".overflow"},      32'(bus.overflow),      32'(m_ovf));
    endtask

    // Advance the model with the currently driven inputs, clock the DUT, then compare.
    task automatic tick(input string tag);
        int sz;
        sz = m_q.size();
        case (m_phase)
            0: if (bus.imageStart) begin
                m_phase = 1; m_pix = 0; m_q.delete(); m_act = 0; m_ovf = 0;
            end
            1: if (bus.pixelValid) begin
                if (int'(bus.pixelIn) >= 128) begin
                    if (sz < 1024) begin m_q.push_back(m_pix); m_act++; end
                    else m_ovf = 1;
                end
                m_pix++;
                if (m_pix == 784) m_phase = 2;
            end
            default: begin
                if (bus.dequeue && sz > 0) void'(m_q.pop_front());
                if (bus.inputsRecieved && sz == 0) m_phase = 0;
            end
        endcase
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic feed_image(input int pct);
        int n = 0;
        while (m_phase == 1 && n < 4000) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 99) < pct, img[m_pix],
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            tick("load");
            n++;
        end
        if (n >= 4000) chk("load_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (m_phase == 2 && n < 4000) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 255),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
            tick("drain");
            n++;
        end
        if (n >= 4000) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic start_image();
        drive(1, 0, 0, 0, 0);
        tick("start");
    endtask

    initial begin
        int exp_out[5];
        bit exp_emp[5];

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        reset = 1'b0;

        // Idle for five cycles.
        for (int i = 0; i < 5; i++) tick("idle");

        // start, valid, pix, dq, ir -> rdy, emp, fin, out, act
        vt[0] = '{0, 0,   0, 0, 0, 0, 1, 0, 0, 0};
        vt[1] = '{0, 1, 255, 1, 1, 0, 1, 0, 0, 0};
        vt[2] = '{1, 0,   0, 0, 0, 1, 1, 0, 0, 0};
        vt[3] = '{0, 1, 255, 0, 0, 1, 0, 0, 0, 1};
        vt[4] = '{0, 1, 127, 0, 0, 1, 0, 0, 0, 1};
        vt[5] = '{0, 1, 128, 0, 0, 1, 0, 0, 0, 2};
        vt[6] = '{0, 0, 255, 0, 0, 1, 0, 0, 0, 2};
        vt[7] = '{1, 1,   0, 0, 0, 1, 0, 0, 0, 2};
        vt[8] = '{0, 1, 200, 1, 1, 1, 0, 0, 0, 3};
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].start, vt[i].valid, vt[i].pix, vt[i].dq, vt[i].ir);
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.rdy", i), 32'(bus.pixelReady),    32'(vt[i].rdy));
            chk($sformatf("vec%0d.emp", i), 32'(bus.queueEmpty),    32'(vt[i].emp));
            chk($sformatf("vec%0d.fin", i), 32'(bus.queueFinished), 32'(vt[i].fin));
            chk($sformatf("vec%0d.out", i), 32'(bus.queueOut),      32'(vt[i].out));
            chk($sformatf("vec%0d.act", i), 32'(bus.activeCount),   32'(vt[i].act));
        end
        foreach (img[i]) img[i] = 0;
        img[783] = 255;
        feed_image(100);
        chk("tbl_img.act", 32'(bus.activeCount), 32'd4);
        chk("tbl_img.fin", 32'(bus.queueFinished), 32'd1);
        drain();

        // Sparse image with the threshold edge at pixels 10/11.
        foreach (img[i]) img[i] = 0;
        img[0] = 255; img[5] = 255; img[783] = 255; img[10] = 127; img[11] = 128;
        start_image();
        for (int i = 0; i < IMAGE_PIXELS; i++) begin
            drive(0, 1, img[i], 0, 0);
            if (i == IMAGE_PIXELS - 1) chk("sparse.fin_before_last", 32'(bus.queueFinished), 32'd0);
            tick("sparse");
        end
        chk("sparse.fin", 32'(bus.queueFinished), 32'd1);
        chk("sparse.act", 32'(bus.activeCount), 32'd4);
        chk("sparse.head", 32'(bus.queueOut), 32'd0);
        exp_out = '{5, 11, 783, 0, 0};
        exp_emp = '{0, 0, 0, 1, 1};
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 0);
            tick("pop");
            chk($sformatf("pop%0d.out", k), 32'(bus.queueOut), 32'(exp_out[k]));
            chk($sformatf("pop%0d.emp", k), 32'(bus.queueEmpty), 32'(exp_emp[k]));
        end
        drive(0, 0, 0, 0, 1);
        tick("release");
        chk("release.fin", 32'(bus.queueFinished), 32'd0);

        // All-dark image; imageStart while finished must be ignored.
        foreach (img[i]) img[i] = $urandom_range(0, 127);
        start_image();
        feed_image(80);
        chk("dark.fin", 32'(bus.queueFinished), 32'd1);
        chk("dark.emp", 32'(bus.queueEmpty), 32'd1);
        drive(1, 0, 0, 0, 0);
        tick("dark_start");
        chk("dark_start.fin", 32'(bus.queueFinished), 32'd1);
        drive(0, 0, 0, 0, 1);
        tick("dark_release");
        chk("dark_release.fin", 32'(bus.queueFinished), 32'd0);

        // Asynchronous reset part-way through an all-bright image.
        start_image();
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 255, 0, 0);
            tick("bright");
        end
        chk("bright.act", 32'(bus.activeCount), 32'd300);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_model("midreset");
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick("post_reset");
        foreach (img[i]) img[i] = $urandom_range(0, 255);
        start_image();
        feed_image(90);
        chk("fresh.ovf", 32'(bus.overflow), 32'd0);
        drain();

        // Random images with random handshake gaps.
        for (int r = 0; r < 3; r++) begin
            foreach (img[i]) img[i] = $urandom_range(0, 255);
            start_image();
            feed_image(70);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
